// File: rtl/mem_pkg.sv
// Shared types and address-map helpers for the memory bus arbiter.
// The ROM region is the lowest 8 KiB; every other address uses the RAM timing.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
   typedef enum logic {FETCH, DATA} grant_e;

   localparam logic [15:0] ROM_BASE       = 16'h0000;
   localparam logic [15:0] RAM_BASE       = 16'h2000;
   localparam logic [2:0]  REGION_MSB_ROM = ROM_BASE[15:13];
   localparam logic [2:0]  REGION_MSB_RAM = RAM_BASE[15:13];

   function automatic logic is_rom(input logic [15:0] addr);
      return addr[15:13] == REGION_MSB_ROM;
   endfunction

   function automatic logic is_ram(input logic [15:0] addr);
      return addr[15:13] == REGION_MSB_RAM;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant between the fetch and data ports (combinational).
// On a conflict the port that was not granted last wins; grant 1 selects DATA.
module mem_rr_arbiter
   import mem_pkg::*;
(
   input  logic f_req_i,
   input  logic d_req_i,
   input  logic last_grant_i,
   output logic gnt_valid_o,
   output logic gnt_o
);

   always_comb begin
      gnt_valid_o = f_req_i | d_req_i;
      gnt_o       = FETCH;
      if (f_req_i && d_req_i) begin
         gnt_o = (last_grant_i == FETCH) ? DATA : FETCH;
      end else if (d_req_i) begin
         gnt_o = DATA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between fetch and data requesters, with per-region wait states.
// Optional MEM_WPROT_EN: data writes into ROM are dropped and reported through d_fault.
module mem_bus_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ROM_WAIT = 0,
   parameter int unsigned RAM_WAIT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   output logic        f_ready,
   output logic [7:0]  f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [7:0]  d_wdata,
   output logic        d_ready,
   output logic [7:0]  d_rdata,
   output logic        d_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        busy
);

   localparam logic [3:0] ROM_WAIT_CNT = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_WAIT_CNT = 4'(RAM_WAIT);

   state_e      state_q, state_d;
   grant_e      grant_q, grant_d;
   grant_e      last_grant_q, last_grant_d;
   logic [15:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [3:0]  wait_q, wait_d;
   logic [7:0]  f_rdata_q, f_rdata_d;
   logic [7:0]  d_rdata_q, d_rdata_d;

   logic        arb_valid;
   logic        arb_gnt;
   grant_e      arb_grant;
   logic [15:0] sel_addr;
   logic        blocked;

   mem_rr_arbiter u_arb (
      .f_req_i      (f_req),
      .d_req_i      (d_req),
      .last_grant_i (last_grant_q),
      .gnt_valid_o  (arb_valid),
      .gnt_o        (arb_gnt)
   );

   assign arb_grant = grant_e'(arb_gnt);
   assign sel_addr  = (arb_grant == DATA) ? d_addr : f_addr;

`ifdef MEM_WPROT_EN
   logic fault_q, fault_d;
   assign blocked = (arb_grant == DATA) && d_we && is_rom(d_addr);
`else
   assign blocked = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      wait_d       = wait_q;
      f_rdata_d    = f_rdata_q;
      d_rdata_d    = d_rdata_q;
`ifdef MEM_WPROT_EN
      fault_d      = fault_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d      = arb_grant;
               last_grant_d = arb_grant;
               addr_d       = sel_addr;
               we_d         = (arb_grant == DATA) && d_we;
               if (arb_grant == DATA) begin
                  wdata_d = d_wdata;
               end
               wait_d  = is_rom(sel_addr) ? ROM_WAIT_CNT : RAM_WAIT_CNT;
               // A blocked write skips the bus entirely and only reports completion.
               state_d = blocked ? DONE : ACCESS;
`ifdef MEM_WPROT_EN
               fault_d = blocked;
`endif
            end
         end
         ACCESS: begin
            if (wait_q == 4'd0) begin
               state_d = DONE;
               if (!we_q) begin
                  if (grant_q == FETCH) begin
                     f_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= FETCH;
         last_grant_q <= FETCH;
         addr_q       <= 16'h0000;
         we_q         <= 1'b0;
         wdata_q      <= 8'h00;
         wait_q       <= 4'd0;
         f_rdata_q    <= 8'h00;
         d_rdata_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         wait_q       <= wait_d;
         f_rdata_q    <= f_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

`ifdef MEM_WPROT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`endif

   // Strobes decode straight from the state register so an async reset drops them at once.
   assign mem_read  = (state_q == ACCESS) && !we_q;
   assign mem_write = (state_q == ACCESS) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign f_ready   = (state_q == DONE) && (grant_q == FETCH);
   assign d_ready   = (state_q == DONE) && (grant_q == DATA);
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);

`ifdef MEM_WPROT_EN
   assign d_fault = d_ready && fault_q;
`else
   assign d_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed timing/arbitration cases, then random traffic.
// Expectations follow MEM_WPROT_EN when it is defined for the build.
module tb_mem_bus_arbiter;

   localparam int unsigned ROM_WAIT = 0;
   localparam int unsigned RAM_WAIT = 1;
`ifdef MEM_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = 16'h0000;
   logic        f_ready;
   logic [7:0]  f_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [7:0]  d_wdata = 8'h00;
   logic        d_ready;
   logic [7:0]  d_rdata;
   logic        d_fault;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ROM_WAIT (ROM_WAIT),
      .RAM_WAIT (RAM_WAIT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_ready   (f_ready),
      .f_rdata   (f_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_fault   (d_fault),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Memory contents are a fixed function of address; writes are checked, not stored.
   function automatic logic [7:0] pat(input logic [15:0] a);
      if (a == 16'h0010) return 8'hA5;
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic int strobe_len(input logic [15:0] a);
      return (a[15:13] == 3'b000) ? int'(ROM_WAIT) + 1 : int'(RAM_WAIT) + 1;
   endfunction

   always_comb mem_rdata = mem_read ? pat(mem_addr) : 8'h00;

   typedef struct {
      logic       we;
      logic [7:0] rdata;
      logic       fault;
   } d_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          len;
   } w_exp_t;

   logic [7:0] f_q[$];
   d_exp_t     d_q[$];
   w_exp_t     w_q[$];
   logic [7:0] d_last = 8'h00;

   int checks = 0;
   int errors = 0;
   int ovl = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fetch(input logic [15:0] a);
      f_q.push_back(pat(a));
   endtask

   task automatic push_data(input logic we, input logic [15:0] a, input logic [7:0] wd);
      logic fault;
      fault = WPROT && we && (a[15:13] == 3'b000);
      if (!we) d_last = pat(a);
      d_q.push_back('{we, d_last, fault});
      if (we && !fault) w_q.push_back('{a, wd, strobe_len(a)});
   endtask

   // Monitor: pops expectations on every ready pulse and tracks each write strobe.
   logic   w_act = 1'b0;
   int     w_len = 0;
   w_exp_t w_cur;
   initial begin
      forever begin
         tick();
         if (mem_read && mem_write) ovl++;
         if (!reset_n) begin
            w_act = 1'b0;
         end else begin
            if (f_ready) begin
               if (f_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL f_ready_extra: got ready expected none");
               end else begin
                  chk("f_rdata", f_rdata, f_q.pop_front());
               end
            end
            if (d_ready) begin
               if (d_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL d_ready_extra: got ready expected none");
               end else begin
                  d_exp_t e;
                  e = d_q.pop_front();
                  chk("d_rdata", d_rdata, e.rdata);
                  chk("d_fault", d_fault, e.fault);
               end
            end else begin
               chk("d_fault_idle", d_fault, 0);
            end
            if (mem_write && !w_act) begin
               if (w_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL mem_write_extra: got write at %0h expected none", mem_addr);
               end else begin
                  w_cur = w_q.pop_front();
                  chk("w_addr", mem_addr, w_cur.addr);
                  chk("w_data", mem_wdata, w_cur.data);
               end
               w_act = 1'b1;
               w_len = 1;
            end else if (mem_write && w_act) begin
               w_len++;
            end else if (!mem_write && w_act) begin
               chk("w_len", w_len, w_cur.len);
               w_act = 1'b0;
            end
         end
      end
   end

   task automatic single(input bit is_d, input logic we, input logic [15:0] a,
                         input logic [7:0] wd, input int exp_lat, input int exp_strobe,
                         input string name);
      int   n = 0;
      int   s = 0;
      logic rdy;
      if (is_d) begin
         push_data(we, a, wd);
         d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
      end else begin
         push_fetch(a);
         f_addr = a; f_req = 1'b1;
      end
      do begin
         tick();
         n++;
         if (mem_read || mem_write) s++;
         rdy = is_d ? d_ready : f_ready;
      end while (!rdy && n < 40);
      f_req = 1'b0;
      d_req = 1'b0;
      chk({name, "_latency"}, n, exp_lat);
      chk({name, "_strobes"}, s, exp_strobe);
      tick();
   endtask

   task automatic fetch_agent(input int count);
      for (int i = 0; i < count; i++) begin
         int gap = $urandom_range(0, 2);
         int k = 0;
         logic [15:0] a;
         if (gap > 0) begin
            f_req = 1'b0;
            repeat (gap) tick();
         end
         a = 16'($urandom);
         push_fetch(a);
         f_addr = a;
         f_req  = 1'b1;
         do begin tick(); k++; end while (!f_ready && k < 64);
         if (!f_ready) chk("fetch_timeout", 0, 1);
      end
      f_req = 1'b0;
   endtask

   task automatic data_agent(input int count);
      for (int i = 0; i < count; i++) begin
         int gap = $urandom_range(0, 2);
         int k = 0;
         logic        we;
         logic [15:0] a;
         logic [7:0]  wd;
         if (gap > 0) begin
            d_req = 1'b0;
            repeat (gap) tick();
         end
         we = 1'($urandom);
         a  = 16'($urandom);
         wd = 8'($urandom);
         push_data(we, a, wd);
         d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
         do begin tick(); k++; end while (!d_ready && k < 64);
         if (!d_ready) chk("data_timeout", 0, 1);
      end
      d_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d_times[$];
      int f_times[$];
      int r;

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {mem_read, mem_write}, 0);
      chk("rst_ready", {f_ready, d_ready, d_fault}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rdata", {f_rdata, d_rdata}, 0);
      reset_n = 1'b1;
      tick();

      // Simultaneous requests: data first, then the re-raised data request loses to fetch.
      push_data(1'b0, 16'h2010, 8'h00);
      push_fetch(16'h0020);
      d_we = 1'b0; d_addr = 16'h2010; d_req = 1'b1;
      f_addr = 16'h0020; f_req = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (d_ready) begin
            d_times.push_back(c);
            if (d_times.size() == 1) begin
               push_data(1'b0, 16'h2011, 8'h00);
               d_addr = 16'h2011;
            end else begin
               d_req = 1'b0;
            end
         end
         if (f_ready) begin
            f_times.push_back(c);
            f_req = 1'b0;
         end
      end
      f_req = 1'b0;
      d_req = 1'b0;
      chk("conflict_d_count", d_times.size(), 2);
      chk("conflict_f_count", f_times.size(), 1);
      if (d_times.size() == 2) begin
         chk("conflict_data_first", d_times[0], 3);
         chk("conflict_data_second", d_times[1], 10);
      end
      if (f_times.size() == 1) chk("conflict_fetch_between", f_times[0], 6);
      tick();

      single(1'b0, 1'b0, 16'h0010, 8'h00, 2, 1, "fetch_rom");
      single(1'b1, 1'b1, 16'h2005, 8'h3C, 3, 2, "wr_ram");
      single(1'b1, 1'b0, 16'h2005, 8'h00, 3, 2, "rd_ram");
      single(1'b0, 1'b0, 16'h4000, 8'h00, 3, 2, "fetch_unmapped");
      single(1'b1, 1'b0, 16'h0050, 8'h00, 2, 1, "rd_rom");
      single(1'b1, 1'b1, 16'h0100, 8'h5A, WPROT ? 1 : 2, WPROT ? 0 : 1, "wr_rom");
      single(1'b1, 1'b1, 16'hFFFF, 8'hC3, 3, 2, "wr_high");

      // Reset in the middle of a write: strobe drops immediately, no ready follows.
      push_data(1'b1, 16'h2005, 8'h3C);
      d_we = 1'b1; d_addr = 16'h2005; d_wdata = 8'h3C; d_req = 1'b1;
      tick();
      chk("abort_write_on", mem_write, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_strobe_drop", {mem_read, mem_write}, 0);
      chk("abort_busy", busy, 0);
      d_req = 1'b0;
      r = 0;
      repeat (3) begin
         tick();
         r += int'(f_ready | d_ready);
      end
      chk("abort_no_ready", r, 0);
      d_q.delete();
      w_q.delete();
      d_last = 8'h00;
      reset_n = 1'b1;
      tick();
      chk("post_reset_busy", busy, 0);
      single(1'b0, 1'b0, 16'h0010, 8'h00, 2, 1, "post_reset_fetch");

      fork
         fetch_agent(150);
         data_agent(150);
      join
      repeat (4) tick();

      chk("f_pending", f_q.size(), 0);
      chk("d_pending", d_q.size(), 0);
      chk("w_pending", w_q.size(), 0);
      chk("strobe_overlap", ovl, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
